// File: rtl/vga_osd_wr_ctrl.sv
// OSD frame-buffer write controller: single-pixel writes, clipped rectangle fills
// and full-screen clears, serialised onto one registered RAM write port.
module vga_osd_wr_ctrl #(
  parameter int H_ACT = 640,
  parameter int V_ACT = 480
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_N,
  input  logic        iPIX_REQ,
  input  logic [9:0]  iPIX_X,
  input  logic [8:0]  iPIX_Y,
  input  logic        iPIX_DATA,
  output logic        oPIX_ACK,
  input  logic        iFILL_REQ,
  input  logic [9:0]  iFILL_X0,
  input  logic [8:0]  iFILL_Y0,
  input  logic [9:0]  iFILL_W,
  input  logic [8:0]  iFILL_H,
  input  logic        iFILL_DATA,
  input  logic        iCLR_REQ,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oERR,
  output logic [18:0] oWR_ADDR,
  output logic        oWR_DATA,
  output logic        oWR_EN
);

  localparam logic [10:0] H_LIM    = 11'(H_ACT);
  localparam logic [9:0]  V_LIM    = 10'(V_ACT);
  localparam logic [18:0] PIX_LAST = 19'(H_ACT * V_ACT - 1);

  typedef enum logic [1:0] {IDLE, FILL, CLEAR} state_t;

  state_t      state_q, state_d;
  logic        clr_pend_q, clr_pend_d;
  logic        fill_pend_q, fill_pend_d;
  logic [9:0]  fx0_q, fx0_d;
  logic [8:0]  fy0_q, fy0_d;
  logic [9:0]  fw_q, fw_d;
  logic [8:0]  fh_q, fh_d;
  logic        fdata_q, fdata_d;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic [9:0]  xs_q, xs_d;
  logic [10:0] xe_q, xe_d;
  logic [9:0]  ye_q, ye_d;
  logic        cdata_q, cdata_d;
  logic [18:0] clr_addr_q, clr_addr_d;
  logic        finish_q, finish_d;
  logic        wr_en_q, wr_en_d;
  logic [18:0] wr_addr_q, wr_addr_d;
  logic        wr_data_q, wr_data_d;
  logic        pix_ack_q, pix_ack_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [10:0] fill_xsum, fill_xe;
  logic [9:0]  fill_ysum, fill_ye;
  logic        fill_empty;
  logic        fill_grant, clr_grant;

  function automatic logic [18:0] pix_addr(input logic [9:0] x, input logic [8:0] y);
    return 19'(y) * 19'(H_ACT) + 19'(x);
  endfunction

  // Clip against the screen edge with sums one bit wider than the operands.
  always_comb begin
    fill_xsum  = {1'b0, fx0_q} + {1'b0, fw_q};
    fill_ysum  = {1'b0, fy0_q} + {1'b0, fh_q};
    fill_xe    = (fill_xsum > H_LIM) ? H_LIM : fill_xsum;
    fill_ye    = (fill_ysum > V_LIM) ? V_LIM : fill_ysum;
    fill_empty = (fw_q == 10'd0) || (fh_q == 9'd0) ||
                 ({1'b0, fx0_q} >= H_LIM) || ({1'b0, fy0_q} >= V_LIM);
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    xs_d       = xs_q;
    xe_d       = xe_q;
    ye_d       = ye_q;
    cdata_d    = cdata_q;
    clr_addr_d = clr_addr_q;
    finish_d   = 1'b0;
    wr_en_d    = 1'b0;
    wr_addr_d  = 19'd0;
    wr_data_d  = 1'b0;
    pix_ack_d  = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    fill_grant = 1'b0;
    clr_grant  = 1'b0;

    case (state_q)
      IDLE: begin
        // finish_q marks the cycle the last write is on the port; no new grant then.
        if (finish_q) begin
          done_d = 1'b1;
        end else if (clr_pend_q) begin
          clr_grant  = 1'b1;
          state_d    = CLEAR;
          clr_addr_d = 19'd0;
        end else if (fill_pend_q) begin
          fill_grant = 1'b1;
          if (fill_empty) begin
            done_d = 1'b1;
          end else begin
            state_d = FILL;
            x_d     = fx0_q;
            y_d     = fy0_q;
            xs_d    = fx0_q;
            xe_d    = fill_xe;
            ye_d    = fill_ye;
            cdata_d = fdata_q;
          end
        end else if (iPIX_REQ && !pix_ack_q) begin
          pix_ack_d = 1'b1;
          if (({1'b0, iPIX_X} < H_LIM) && ({1'b0, iPIX_Y} < V_LIM)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = pix_addr(iPIX_X, iPIX_Y);
            wr_data_d = iPIX_DATA;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FILL: begin
        wr_en_d   = 1'b1;
        busy_d    = 1'b1;
        wr_addr_d = pix_addr(x_q, y_q);
        wr_data_d = cdata_q;
        if (({1'b0, x_q} + 11'd1) == xe_q) begin
          x_d = xs_q;
          if (({1'b0, y_q} + 10'd1) == ye_q) begin
            state_d  = IDLE;
            finish_d = 1'b1;
          end else begin
            y_d = y_q + 9'd1;
          end
        end else begin
          x_d = x_q + 10'd1;
        end
      end
      CLEAR: begin
        wr_en_d   = 1'b1;
        busy_d    = 1'b1;
        wr_addr_d = clr_addr_q;
        wr_data_d = 1'b0;
        if (clr_addr_q == PIX_LAST) begin
          state_d  = IDLE;
          finish_d = 1'b1;
        end else begin
          clr_addr_d = clr_addr_q + 19'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending requests: a pulse is captured only when no request of its kind is waiting.
  always_comb begin
    clr_pend_d  = clr_pend_q;
    fill_pend_d = fill_pend_q;
    fx0_d       = fx0_q;
    fy0_d       = fy0_q;
    fw_d        = fw_q;
    fh_d        = fh_q;
    fdata_d     = fdata_q;
    if (iCLR_REQ && !clr_pend_q) begin
      clr_pend_d = 1'b1;
    end else if (clr_grant) begin
      clr_pend_d = 1'b0;
    end
    if (iFILL_REQ && !fill_pend_q) begin
      fill_pend_d = 1'b1;
      fx0_d       = iFILL_X0;
      fy0_d       = iFILL_Y0;
      fw_d        = iFILL_W;
      fh_d        = iFILL_H;
      fdata_d     = iFILL_DATA;
    end else if (fill_grant) begin
      fill_pend_d = 1'b0;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= IDLE;
      clr_pend_q  <= 1'b0;
      fill_pend_q <= 1'b0;
      fx0_q       <= 10'd0;
      fy0_q       <= 9'd0;
      fw_q        <= 10'd0;
      fh_q        <= 9'd0;
      fdata_q     <= 1'b0;
      x_q         <= 10'd0;
      y_q         <= 9'd0;
      xs_q        <= 10'd0;
      xe_q        <= 11'd0;
      ye_q        <= 10'd0;
      cdata_q     <= 1'b0;
      clr_addr_q  <= 19'd0;
      finish_q    <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 19'd0;
      wr_data_q   <= 1'b0;
      pix_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_pend_q  <= clr_pend_d;
      fill_pend_q <= fill_pend_d;
      fx0_q       <= fx0_d;
      fy0_q       <= fy0_d;
      fw_q        <= fw_d;
      fh_q        <= fh_d;
      fdata_q     <= fdata_d;
      x_q         <= x_d;
      y_q         <= y_d;
      xs_q        <= xs_d;
      xe_q        <= xe_d;
      ye_q        <= ye_d;
      cdata_q     <= cdata_d;
      clr_addr_q  <= clr_addr_d;
      finish_q    <= finish_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      pix_ack_q   <= pix_ack_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign oWR_EN   = wr_en_q;
  assign oWR_ADDR = wr_addr_q;
  assign oWR_DATA = wr_data_q;
  assign oPIX_ACK = pix_ack_q;
  assign oBUSY    = busy_q;
  assign oDONE    = done_q;
  assign oERR     = err_q;

endmodule

// File: tb/tb_vga_osd_wr_ctrl.sv
// Directed bench: dut_a runs at the default 640x480 geometry, dut_b at 16x8 so a
// complete clear stays short; sel picks which one receives requests and is observed.
module tb_vga_osd_wr_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;
  logic        pix_req, pix_data, fill_req, fill_data, clr_req;
  logic [9:0]  pix_x, fill_x0, fill_w;
  logic [8:0]  pix_y, fill_y0, fill_h;

  logic        a_ack, a_busy, a_done, a_err, a_wr_data, a_wr_en;
  logic [18:0] a_wr_addr;
  logic        b_ack, b_busy, b_done, b_err, b_wr_data, b_wr_en;
  logic [18:0] b_wr_addr;
  logic        obs_ack, obs_busy, obs_done, obs_err, obs_wr_data, obs_wr_en;
  logic [18:0] obs_wr_addr;

  assign obs_ack     = sel ? b_ack     : a_ack;
  assign obs_busy    = sel ? b_busy    : a_busy;
  assign obs_done    = sel ? b_done    : a_done;
  assign obs_err     = sel ? b_err     : a_err;
  assign obs_wr_data = sel ? b_wr_data : a_wr_data;
  assign obs_wr_en   = sel ? b_wr_en   : a_wr_en;
  assign obs_wr_addr = sel ? b_wr_addr : a_wr_addr;

  vga_osd_wr_ctrl dut_a (
    .iVGA_CLK(clk), .iRST_N(rst_n),
    .iPIX_REQ(pix_req & ~sel), .iPIX_X(pix_x), .iPIX_Y(pix_y), .iPIX_DATA(pix_data),
    .oPIX_ACK(a_ack),
    .iFILL_REQ(fill_req & ~sel), .iFILL_X0(fill_x0), .iFILL_Y0(fill_y0),
    .iFILL_W(fill_w), .iFILL_H(fill_h), .iFILL_DATA(fill_data),
    .iCLR_REQ(clr_req & ~sel),
    .oBUSY(a_busy), .oDONE(a_done), .oERR(a_err),
    .oWR_ADDR(a_wr_addr), .oWR_DATA(a_wr_data), .oWR_EN(a_wr_en)
  );

  vga_osd_wr_ctrl #(.H_ACT(16), .V_ACT(8)) dut_b (
    .iVGA_CLK(clk), .iRST_N(rst_n),
    .iPIX_REQ(pix_req & sel), .iPIX_X(pix_x), .iPIX_Y(pix_y), .iPIX_DATA(pix_data),
    .oPIX_ACK(b_ack),
    .iFILL_REQ(fill_req & sel), .iFILL_X0(fill_x0), .iFILL_Y0(fill_y0),
    .iFILL_W(fill_w), .iFILL_H(fill_h), .iFILL_DATA(fill_data),
    .iCLR_REQ(clr_req & sel),
    .oBUSY(b_busy), .oDONE(b_done), .oERR(b_err),
    .oWR_ADDR(b_wr_addr), .oWR_DATA(b_wr_data), .oWR_EN(b_wr_en)
  );

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];  // {data, addr} of each expected RAM write, in order

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int limit);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!obs_ack && n < limit);
  endtask

  task automatic pix_op(input logic [9:0] x, input logic [8:0] y, input logic d,
                        input logic ok, input logic [18:0] addr);
    pix_x = x; pix_y = y; pix_data = d; pix_req = 1'b1;
    wait_ack(8);
    check("pix_ack", obs_ack, 1);
    check("pix_wr_en", obs_wr_en, ok);
    check("pix_err", obs_err, !ok);
    if (ok) begin
      check("pix_addr", obs_wr_addr, addr);
      check("pix_data", obs_wr_data, d);
    end
    pix_req = 1'b0;
    tick();
    check("pix_ack_one_cycle", obs_ack, 0);
  endtask

  task automatic fill_pulse(input logic [9:0] x0, input logic [8:0] y0, input logic [9:0] w,
                            input logic [8:0] h, input logic d, input logic with_clr);
    fill_x0 = x0; fill_y0 = y0; fill_w = w; fill_h = h; fill_data = d;
    fill_req = 1'b1;
    clr_req  = with_clr;
    tick();
    fill_req = 1'b0;
    clr_req  = 1'b0;
  endtask

  // Observe until n_done completion pulses; writes are matched against exp_q.
  task automatic collect(input int max_cyc, input int n_done, input int inj,
                         output int n_wr, output int n_busy, output int n_ack);
    int dones = 0;
    logic [19:0] e;
    n_wr = 0; n_busy = 0; n_ack = 0;
    for (int i = 0; i < max_cyc && dones < n_done; i++) begin
      if (i == inj) begin
        fill_x0 = 10'd0; fill_y0 = 9'd0; fill_w = 10'd1; fill_h = 9'd1; fill_req = 1'b1;
      end
      tick();
      fill_req = 1'b0;
      if (obs_wr_en) begin
        n_wr++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", obs_wr_addr, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("op_wr_addr", obs_wr_addr, e[18:0]);
          check("op_wr_data", obs_wr_data, e[19]);
        end
      end
      if (obs_busy) n_busy++;
      if (obs_ack) n_ack++;
      if (obs_done) begin
        dones++;
        check("busy_low_at_done", obs_busy, 0);
      end
    end
    check("done_count", dones, n_done);
    check("writes_left", exp_q.size(), 0);
  endtask

  task automatic quiet(input int n);
    int wr = 0, dn = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (obs_wr_en) wr++;
      if (obs_done) dn++;
    end
    check("quiet_writes", wr, 0);
    check("quiet_done", dn, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wr_en"}, obs_wr_en, 0);
    check({tag, "_wr_addr"}, obs_wr_addr, 0);
    check({tag, "_wr_data"}, obs_wr_data, 0);
    check({tag, "_ack"}, obs_ack, 0);
    check({tag, "_busy"}, obs_busy, 0);
    check({tag, "_done"}, obs_done, 0);
    check({tag, "_err"}, obs_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_wr, n_busy, n_ack, cnt;
    rst_n = 1'b0; sel = 1'b0;
    pix_req = 1'b0; pix_x = '0; pix_y = '0; pix_data = 1'b0;
    fill_req = 1'b0; fill_x0 = '0; fill_y0 = '0; fill_w = '0; fill_h = '0; fill_data = 1'b0;
    clr_req = 1'b0;
    repeat (3) tick();
    check_outputs_zero("reset_a");
    sel = 1'b1;
    #1;
    check_outputs_zero("reset_b");
    sel = 1'b0;
    rst_n = 1'b1;
    tick();

    // Single pixels on the 640x480 instance, including both range edges.
    pix_op(10'd5, 9'd2, 1'b1, 1'b1, 19'd1285);
    pix_op(10'd640, 9'd0, 1'b1, 1'b0, 19'd0);
    pix_op(10'd0, 9'd480, 1'b1, 1'b0, 19'd0);
    pix_op(10'd639, 9'd479, 1'b0, 1'b1, 19'd307199);

    // Fill clipped at the bottom-right corner: 8 writes remain.
    for (int a = 306556; a <= 306559; a++) exp_q.push_back({1'b1, 19'(a)});
    for (int a = 307196; a <= 307199; a++) exp_q.push_back({1'b1, 19'(a)});
    fill_pulse(10'd636, 9'd478, 10'd8, 9'd4, 1'b1, 1'b0);
    collect(40, 1, -1, n_wr, n_busy, n_ack);
    check("clip_fill_writes", n_wr, 8);
    check("clip_fill_busy", n_busy, 8);
    quiet(5);

    // Interior 3x2 fill of zeros spanning two rows.
    exp_q.push_back({1'b0, 19'd642});  exp_q.push_back({1'b0, 19'd643});
    exp_q.push_back({1'b0, 19'd644});  exp_q.push_back({1'b0, 19'd1282});
    exp_q.push_back({1'b0, 19'd1283}); exp_q.push_back({1'b0, 19'd1284});
    fill_pulse(10'd2, 9'd1, 10'd3, 9'd2, 1'b0, 1'b0);
    collect(40, 1, -1, n_wr, n_busy, n_ack);
    check("inner_fill_writes", n_wr, 6);
    check("inner_fill_busy", n_busy, 6);

    // Empty fills: zero width, zero height, origin off-screen.
    fill_pulse(10'd10, 9'd10, 10'd0, 9'd3, 1'b1, 1'b0);
    collect(10, 1, -1, n_wr, n_busy, n_ack);
    check("empty_w_writes", n_wr, 0);
    check("empty_w_busy", n_busy, 0);
    fill_pulse(10'd10, 9'd10, 10'd4, 9'd0, 1'b1, 1'b0);
    collect(10, 1, -1, n_wr, n_busy, n_ack);
    check("empty_h_writes", n_wr, 0);
    fill_pulse(10'd640, 9'd0, 10'd5, 9'd5, 1'b1, 1'b0);
    collect(10, 1, -1, n_wr, n_busy, n_ack);
    check("empty_x0_writes", n_wr, 0);
    check("empty_x0_busy", n_busy, 0);

    // Clear interrupted by reset after 1000 writes.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 1100 && cnt < 1000; i++) begin
      tick();
      if (obs_wr_en) begin
        if (obs_wr_addr !== 19'(cnt) || obs_wr_data !== 1'b0)
          check("clear_seq_addr", obs_wr_addr, cnt);
        cnt++;
      end
    end
    check("clear_reached_1000", cnt, 1000);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_clear_reset");
    tick();
    tick();
    rst_n = 1'b1;
    quiet(60);

    // 16x8 instance: clear and fill together, a second fill while pending, a held pixel.
    sel = 1'b1;
    tick();
    for (int a = 0; a < 128; a++) exp_q.push_back({1'b0, 19'(a)});
    exp_q.push_back({1'b1, 19'd35}); exp_q.push_back({1'b1, 19'd36});
    exp_q.push_back({1'b1, 19'd51}); exp_q.push_back({1'b1, 19'd52});
    fill_pulse(10'd3, 9'd2, 10'd2, 9'd2, 1'b1, 1'b1);
    pix_x = 10'd1; pix_y = 9'd1; pix_data = 1'b1; pix_req = 1'b1;
    collect(400, 2, 20, n_wr, n_busy, n_ack);
    check("combo_writes", n_wr, 132);
    check("combo_busy", n_busy, 132);
    check("combo_pix_stalled", n_ack, 0);
    wait_ack(6);
    check("combo_pix_ack", obs_ack, 1);
    check("combo_pix_wr_en", obs_wr_en, 1);
    check("combo_pix_addr", obs_wr_addr, 17);
    check("combo_pix_data", obs_wr_data, 1);
    pix_req = 1'b0;
    quiet(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_osd_wr_ctrl.md
VGA_OSD_WR_CTRL -- requirements
Module: vga_osd_wr_ctrl

Interface
REQ-001 SHALL have parameters: H_ACT, default 640, active pixels per line; V_ACT, default 480, active lines per frame.
REQ-002 SHALL have ports, one per line, as follows:
- iVGA_CLK  input  1  clock; all logic rising-edge.
- iRST_N  input  1  reset, asynchronous, active-low.
- iPIX_REQ  input  1  single-pixel write request; level, held until oPIX_ACK.
- iPIX_X  input  10  pixel column.
- iPIX_Y  input  9  pixel row.
- iPIX_DATA  input  1  pixel value.
- oPIX_ACK  output  1  one-cycle pixel acknowledge.
- iFILL_REQ  input  1  rectangle-fill start; one-cycle pulse.
- iFILL_X0  input  10  rectangle left column.
- iFILL_Y0  input  9  rectangle top row.
- iFILL_W  input  10  rectangle width.
- iFILL_H  input  9  rectangle height.
- iFILL_DATA  input  1  fill value.
- iCLR_REQ  input  1  full-screen clear-to-0; one-cycle pulse.
- oBUSY  output  1  high while FILL or CLEAR active.
- oDONE  output  1  one-cycle pulse at fill/clear completion.
- oERR  output  1  one-cycle pulse on rejected out-of-range pixel.
- oWR_ADDR  output  19  OSD RAM write address.
- oWR_DATA  output  1  OSD RAM write data.
- oWR_EN  output  1  OSD RAM write enable; RAM write clock tied to iVGA_CLK.

Function
REQ-003 SHALL use FSM states IDLE, FILL, CLEAR.
REQ-004 SHALL register all outputs.
REQ-005 SHALL produce at most one RAM write per cycle.
REQ-006 SHALL compute the write address as y*H_ACT+x, for default (y<<9)+(y<<7)+x, 19 bits, no overflow for in-range x,y.
REQ-007 SHALL latch a fill pulse, including X0/Y0/W/H/DATA captured that cycle, and a clear pulse into pending flags in any state; a second pulse of the same kind while pending is dropped.
REQ-008 SHALL, in IDLE, grant priority pending clear > pending fill > iPIX_REQ, evaluated each cycle.
REQ-009 SHALL, on a pixel grant with x<H_ACT and y<V_ACT, assert oWR_EN=1 with the address and iPIX_DATA and oPIX_ACK=1 on the next cycle.
REQ-010 SHALL, on a pixel grant with x>=H_ACT or y>=V_ACT, assert oPIX_ACK=1 and oERR=1 on the next cycle with oWR_EN=0.
REQ-011 SHALL service pixel requests only in IDLE; iPIX_REQ is stalled, with no ACK, while FILL or CLEAR is active.
REQ-012 SHALL, on fill grant, clip the rectangle to the screen: xe=min(X0+W,H_ACT) and ye=min(Y0+H,V_ACT), sums computed 11/10 bits wide with no wrap.
REQ-013 SHALL treat W=0, H=0, X0>=H_ACT or Y0>=V_ACT as an empty fill: no writes, no FILL state entry, oDONE pulses the cycle after grant, oBUSY stays 0.
REQ-014 SHALL, in FILL, write raster order (x inner X0..xe-1, y outer Y0..ye-1), one write per cycle, for exactly (xe-X0)*(ye-Y0) writes.
REQ-015 SHALL, in CLEAR, write data 0 to addresses 0..H_ACT*V_ACT-1 ascending, one per cycle, 307200 writes at defaults.
REQ-016 SHALL hold oBUSY=1 from the first to the last write of a fill/clear, then oBUSY=0 and oDONE=1 the following cycle, with the FSM in IDLE that cycle.
REQ-017 SHALL, for a fill or clear pulse arriving during FILL/CLEAR, serve it after the current operation completes, with no abort; clear pending is served before fill pending.
REQ-018 SHALL drive oWR_EN=0 whenever no write occurs; oWR_ADDR/oWR_DATA are don't-care when oWR_EN=0.

Reset
REQ-019 SHALL, while iRST_N=0, immediately force: state IDLE; pending flags 0; counters 0; oWR_EN, oWR_DATA, oWR_ADDR, oPIX_ACK, oBUSY, oDONE, oERR all 0.
REQ-020 SHALL, on reset mid-fill or mid-clear, abandon the operation with no oDONE and no further writes after release until a new request arrives.

Verification
REQ-021 SHALL pass: pixel REQ x=5,y=2,data=1 -> next cycle oWR_EN=1, oWR_ADDR=1285, oWR_DATA=1, oPIX_ACK=1.
REQ-022 SHALL pass: pixel REQ x=640,y=0 -> oPIX_ACK=1, oERR=1, oWR_EN=0.
REQ-023 SHALL pass: fill X0=636,Y0=478,W=8,H=4,data=1 -> 8 writes at addresses 306556..306559 and 307196..307199, oBUSY high 8 cycles, then oDONE pulse.
REQ-024 SHALL pass: iCLR_REQ and iFILL_REQ in the same cycle -> 307200 zero writes, then the fill, two oDONE pulses; a pixel REQ asserted meanwhile is ACKed only after the second oDONE.
REQ-025 SHALL pass: fill W=0 -> oDONE the cycle after grant, zero writes, oBUSY=0.
REQ-026 SHALL pass: clear, iRST_N low at write 1000 -> outputs 0 at once; after release no writes and no oDONE.
